checkbits_monitor: RTL and testbench

Synthesizable monitor that sits directly downstream of the user-project GPIO checkbits bus (mprj_io[31:16]) in the counter_la_fir test flow. It synchronizes and de-glitches the 16-bit checkbits word and recognises the firmware start (0xAB40) and end (0xAB51) markers. Every distinct stable value between the markers is captured into a FIFO and streamed out over a valid/ready port, and the cycles spent in the marked region are counted. This makes FIR results (e.g. 918) available to on-chip logic or a bench without polling pads.

---
 rtl/checkbits_monitor_if.sv | 10 +
 rtl/checkbits_monitor.sv | 162 ++++++++++++++++
 tb/tb_checkbits_monitor.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/checkbits_monitor_if.sv
// Result stream from checkbits_monitor: head word plus valid/ready handshake.
// A beat transfers on any cycle where out_valid and out_ready are both high.
interface checkbits_monitor_if;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/checkbits_monitor.sv
// Syncs/de-glitches checkbits, tracks start/end markers, queues in-run values.
// Latency STABLE_CYCLES+2 from pad to outputs; out_ready low fills FIFO, then drops captures (sticky overflow).
module checkbits_monitor #(
    parameter int          STABLE_CYCLES = 4,
    parameter logic [15:0] START_MARK    = 16'hAB40,
    parameter logic [15:0] END_MARK      = 16'hAB51,
    parameter int          FIFO_DEPTH    = 8,
    parameter int          CNT_W         = 32
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [15:0]          checkbits_i,
    checkbits_monitor_if.master  out_if,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [CNT_W-1:0]     cycle_count
);

    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    logic [15:0]       sync1_q;
    logic [15:0]       sync_q;
    logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
    logic [15:0]       last_acc_q, last_acc_d;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [15:0]       mem_q [FIFO_DEPTH];

    logic accept;
    logic run_entry;
    logic restart;
    logic push;
    logic pop;
    logic wr_en;
    logic empty;
    logic full;

    // Counter tracks the value sync_q is about to take, so it reads 1 in the first cycle of a new word.
    always_comb begin
        stab_cnt_d = stab_cnt_q;
        if (sync1_q != sync_q) begin
            stab_cnt_d = STAB_W'(1);
        end else if (stab_cnt_q != STAB_MAX) begin
            stab_cnt_d = stab_cnt_q + STAB_W'(1);
        end
    end

    assign accept     = (stab_cnt_q == STAB_MAX) && (sync_q != last_acc_q);
    assign last_acc_d = accept ? sync_q : last_acc_q;

    always_comb begin
        state_d   = state_q;
        run_entry = 1'b0;
        restart   = 1'b0;
        push      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && sync_q == START_MARK) begin
                    state_d   = ST_RUN;
                    run_entry = 1'b1;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (sync_q == END_MARK) begin
                        state_d = ST_DONE;
                    end else if (sync_q == START_MARK) begin
                        restart = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (accept && sync_q == START_MARK) begin
                    state_d   = ST_RUN;
                    run_entry = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop   = !empty && out_if.out_ready;
    assign wr_en = push && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (run_entry || restart) begin
            cnt_d = '0;
        end else if (state_q == ST_RUN && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (run_entry) begin
            ovf_d = 1'b0;
        end else if (push && full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync1_q    <= '0;
            sync_q     <= '0;
            stab_cnt_q <= '0;
            last_acc_q <= '0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            sync1_q    <= checkbits_i;
            sync_q     <= sync1_q;
            stab_cnt_q <= stab_cnt_d;
            last_acc_q <= last_acc_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage needs no reset: pointers define validity and out_data is masked when empty.
    always_ff @(posedge wb_clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= sync_q;
        end
    end

    assign out_if.out_valid = !empty;
    assign out_if.out_data  = empty ? 16'h0000 : mem_q[rd_ptr_q[PTR_W-1:0]];
    assign busy             = (state_q == ST_RUN);
    assign done             = (state_q == ST_DONE);
    assign overflow         = ovf_q;
    assign cycle_count      = cnt_q;

endmodule

// File: tb/tb_checkbits_monitor.sv
// Table-driven bench for checkbits_monitor with a scoreboard on the result stream.
module tb_checkbits_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cb  = 16'h0000;
    logic        busy, done, overflow;
    logic [31:0] cycle_count;

    checkbits_monitor_if mon_if();

    checkbits_monitor dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .checkbits_i (cb),
        .out_if      (mon_if),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] sb_q[$];

    typedef struct {
        logic [15:0] val;
        int          hold;
        bit          push;
        bit          exp_busy;
        bit          exp_done;
        bit          chk_cnt;
        int          exp_cnt;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Consumer side: every handshake beat must match the oldest expected capture.
    always @(negedge clk) begin
        if (!rst && mon_if.out_valid === 1'b1 && mon_if.out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat: unexpected out_data %0h with empty scoreboard", mon_if.out_data);
            end else begin
                chk("beat", {16'h0, mon_if.out_data}, {16'h0, sb_q.pop_front()});
            end
        end
    end

    initial begin
        tbl[0]  = '{16'h0005, 10, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        tbl[1]  = '{16'hAB40,  5, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        tbl[2]  = '{16'hAB40,  1, 1'b0, 1'b1, 1'b0, 1'b1, 0};
        tbl[3]  = '{16'hAB40, 14, 1'b0, 1'b1, 1'b0, 1'b1, 14};
        tbl[4]  = '{16'h0396, 20, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[5]  = '{16'hAB51, 20, 1'b0, 1'b0, 1'b1, 1'b1, 40};
        tbl[6]  = '{16'h0006, 10, 1'b0, 1'b0, 1'b1, 1'b1, 40};
        tbl[7]  = '{16'hAB40, 20, 1'b0, 1'b1, 1'b0, 1'b1, 14};
        tbl[8]  = '{16'h0396, 20, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[9]  = '{16'h1234,  3, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[10] = '{16'h0396, 10, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[11] = '{16'h0397,  4, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[12] = '{16'hAB51, 20, 1'b0, 1'b0, 1'b1, 1'b0, 0};

        mon_if.out_ready = 1'b1;
        cyc(3);
        chk("rst busy", {31'h0, busy}, 32'h0);
        chk("rst done", {31'h0, done}, 32'h0);
        chk("rst overflow", {31'h0, overflow}, 32'h0);
        chk("rst out_valid", {31'h0, mon_if.out_valid}, 32'h0);
        chk("rst out_data", {16'h0, mon_if.out_data}, 32'h0);
        chk("rst cycle_count", cycle_count, 32'h0);
        rst = 1'b0;
        cyc(8);
        chk("zero input not accepted", {31'h0, busy}, 32'h0);

        for (int i = 0; i < 13; i++) begin
            cb = tbl[i].val;
            if (tbl[i].push) sb_q.push_back(tbl[i].val);
            cyc(tbl[i].hold);
            chk($sformatf("vec%0d busy", i), {31'h0, busy}, {31'h0, tbl[i].exp_busy});
            chk($sformatf("vec%0d done", i), {31'h0, done}, {31'h0, tbl[i].exp_done});
            chk($sformatf("vec%0d out_valid", i), {31'h0, mon_if.out_valid}, 32'h0);
            if (tbl[i].chk_cnt) chk($sformatf("vec%0d cycle_count", i), cycle_count, tbl[i].exp_cnt);
        end
        chk("table scoreboard drained", sb_q.size(), 0);

        // Overflow: nine captures into an eight-entry FIFO with the consumer stalled.
        cb = 16'hAB40;
        cyc(20);
        chk("ovf run busy", {31'h0, busy}, 32'h1);
        mon_if.out_ready = 1'b0;
        for (int v = 1; v <= 9; v++) begin
            cb = 16'(v);
            if (v <= 8) sb_q.push_back(16'(v));
            cyc(5);
        end
        cyc(5);
        chk("ovf sticky set", {31'h0, overflow}, 32'h1);
        chk("ovf head valid", {31'h0, mon_if.out_valid}, 32'h1);
        chk("ovf head data", {16'h0, mon_if.out_data}, 32'h1);
        mon_if.out_ready = 1'b1;
        cyc(12);
        chk("ovf drain count", sb_q.size(), 0);
        chk("ovf drained valid", {31'h0, mon_if.out_valid}, 32'h0);
        chk("ovf held after drain", {31'h0, overflow}, 32'h1);
        cb = 16'hAB51;
        cyc(10);
        chk("ovf done", {31'h0, done}, 32'h1);
        cb = 16'hAB40;
        cyc(10);
        chk("ovf cleared by start", {31'h0, overflow}, 32'h0);
        chk("ovf restart busy", {31'h0, busy}, 32'h1);

        // Full FIFO with a pop in the same cycle as the push: nothing dropped.
        mon_if.out_ready = 1'b0;
        for (int v = 8'h11; v <= 8'h18; v++) begin
            cb = 16'(v);
            sb_q.push_back(16'(v));
            cyc(5);
        end
        cyc(3);
        chk("full no ovf yet", {31'h0, overflow}, 32'h0);
        cb = 16'h0019;
        sb_q.push_back(16'h0019);
        cyc(5);
        mon_if.out_ready = 1'b1;
        cyc(1);
        mon_if.out_ready = 1'b0;
        cyc(5);
        chk("full+pop no ovf", {31'h0, overflow}, 32'h0);
        chk("full+pop entries left", sb_q.size(), 8);
        mon_if.out_ready = 1'b1;
        cyc(12);
        chk("full+pop drained", sb_q.size(), 0);
        chk("full+pop valid", {31'h0, mon_if.out_valid}, 32'h0);

        // Reset while running with entries queued; held start marker re-enters RUN.
        mon_if.out_ready = 1'b0;
        for (int v = 8'h21; v <= 8'h23; v++) begin
            cb = 16'(v);
            sb_q.push_back(16'(v));
            cyc(5);
        end
        cyc(5);
        chk("pre-rst head", {16'h0, mon_if.out_data}, 32'h21);
        chk("pre-rst busy", {31'h0, busy}, 32'h1);
        cb  = 16'hAB40;
        rst = 1'b1;
        cyc(1);
        chk("mid-rst busy", {31'h0, busy}, 32'h0);
        chk("mid-rst done", {31'h0, done}, 32'h0);
        chk("mid-rst out_valid", {31'h0, mon_if.out_valid}, 32'h0);
        chk("mid-rst out_data", {16'h0, mon_if.out_data}, 32'h0);
        chk("mid-rst overflow", {31'h0, overflow}, 32'h0);
        chk("mid-rst cycle_count", cycle_count, 32'h0);
        rst = 1'b0;
        sb_q.delete();
        cyc(5);
        chk("post-rst still idle", {31'h0, busy}, 32'h0);
        cyc(3);
        chk("post-rst busy", {31'h0, busy}, 32'h1);
        chk("post-rst cycle_count", cycle_count, 32'h2);
        chk("post-rst out_valid", {31'h0, mon_if.out_valid}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
